// File: rtl/io_map_pkg.sv
// Purpose: shared memory map, field layout and widths for the I/O bridge.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package io_map_pkg;

    localparam logic [31:0] MAP_DISP_ADDR = 32'hFFFF_F000;
    localparam logic [31:0] MAP_LED_ADDR  = 32'hFFFF_F060;
    localparam logic [31:0] MAP_SW_ADDR   = 32'hFFFF_F070;
    localparam logic [31:0] MAP_BTN_ADDR  = 32'hFFFF_F078;

    // Bit positions of the two button fields inside the BTN_ADDR word.
    localparam int STABLE_LSB = 0;
    localparam int EVENT_LSB  = 5;

    localparam int SW_W  = 24;
    localparam int BTN_W = 5;

    // 2 ms at 100 MHz.
    localparam int DEBOUNCE_DEFAULT = 200000;

    typedef enum logic {
        DB_IDLE  = 1'b0,
        DB_COUNT = 1'b1
    } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Purpose: 2-flop synchroniser plus debounce FSM for one button bit.
// Latency: 2 + DEBOUNCE_CYCLES edges from din change to stable; rise is combinational with the accepting edge.
// Backpressure: none; din is sampled every cycle.
module btn_debounce
    import io_map_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             sync_q2;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             stable_nxt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= din;
            sync_q2 <= sync_q1;
        end
    end

    // FSM state, counter and accepted level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= DB_IDLE;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            stable <= stable_nxt;
        end
    end

    // The IDLE->COUNT edge is the first stable sample, so acceptance happens when
    // the incremented count reaches the last value; the counter never passes it.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        stable_nxt = stable;
        rise       = 1'b0;
        cnt_inc    = cnt + 1'b1;
        case (state)
            DB_IDLE: begin
                if (sync_q2 != stable) begin
                    cnt_nxt   = '0;
                    state_nxt = DB_COUNT;
                end
            end
            DB_COUNT: begin
                if (sync_q2 == stable) begin
                    state_nxt = DB_IDLE;
                end else if (cnt_inc == CNT_LAST) begin
                    cnt_nxt    = cnt_inc;
                    stable_nxt = sync_q2;
                    rise       = sync_q2;
                    state_nxt  = DB_IDLE;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: state_nxt = DB_IDLE;
        endcase
    end

endmodule

// File: rtl/io_bridge.sv
// Purpose: memory-mapped bridge from the CPU data bus to display, LEDs, switches and buttons.
// Latency: stores take effect on the store edge; loads are combinational; switches 2 edges, buttons 2+DEBOUNCE_CYCLES edges.
// Backpressure: none; the CPU bus is single-cycle and never stalled.
module io_bridge
    import io_map_pkg::*;
#(
    parameter int          DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter logic [31:0] DISP_ADDR       = MAP_DISP_ADDR,
    parameter logic [31:0] LED_ADDR        = MAP_LED_ADDR,
    parameter logic [31:0] SW_ADDR         = MAP_SW_ADDR,
    parameter logic [31:0] BTN_ADDR        = MAP_BTN_ADDR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     cpu_addr,
    input  logic            cpu_we,
    input  logic [31:0]     cpu_wdata,
    output logic [31:0]     cpu_rdata,
    input  logic [SW_W-1:0] sw_in,
    input  logic [BTN_W-1:0] btn_in,
    output logic [SW_W-1:0] led_out,
    output logic [31:0]     disp_data,
    output logic            disp_en
);

    logic             disp_wr;
    logic             led_wr;
    logic             btn_wr;
    logic [SW_W-1:0]  sw_q1;
    logic [SW_W-1:0]  sw_sync;
    logic [BTN_W-1:0] btn_stable;
    logic [BTN_W-1:0] btn_rise;
    logic [BTN_W-1:0] btn_event;
    logic [BTN_W-1:0] btn_clr;

    assign disp_wr = cpu_we && (cpu_addr == DISP_ADDR);
    assign led_wr  = cpu_we && (cpu_addr == LED_ADDR);
    assign btn_wr  = cpu_we && (cpu_addr == BTN_ADDR);
    assign btn_clr = btn_wr ? cpu_wdata[EVENT_LSB +: BTN_W] : '0;

    // Display register; the strobe stays high across back-to-back stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_data <= '0;
            disp_en   <= 1'b0;
        end else begin
            disp_en <= disp_wr;
            if (disp_wr) begin
                disp_data <= cpu_wdata;
            end
        end
    end

    // LED register; only the low SW_W bits of the store are kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_out <= '0;
        end else if (led_wr) begin
            led_out <= cpu_wdata[SW_W-1:0];
        end
    end

    // Switches are level inputs read by software, so synchronise only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_q1   <= '0;
            sw_sync <= '0;
        end else begin
            sw_q1   <= sw_in;
            sw_sync <= sw_q1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < BTN_W; gi++) begin : g_btn
            btn_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk    (clk),
                .rst    (rst),
                .din    (btn_in[gi]),
                .stable (btn_stable[gi]),
                .rise   (btn_rise[gi])
            );
        end
    endgenerate

    // Sticky press events, write-1-to-clear; a new press beats a same-edge clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_event <= '0;
        end else begin
            btn_event <= (btn_event & ~btn_clr) | btn_rise;
        end
    end

    // Load mux; reads have no side effects.
    always_comb begin
        cpu_rdata = '0;
        case (cpu_addr)
            DISP_ADDR: cpu_rdata = disp_data;
            LED_ADDR:  cpu_rdata[SW_W-1:0] = led_out;
            SW_ADDR:   cpu_rdata[SW_W-1:0] = sw_sync;
            BTN_ADDR: begin
                cpu_rdata[STABLE_LSB +: BTN_W] = btn_stable;
                cpu_rdata[EVENT_LSB +: BTN_W]  = btn_event;
            end
            default:   cpu_rdata = '0;
        endcase
    end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Memory-mapped I/O bridge between the single-cycle CPU data bus and the board peripherals.
- Decodes CPU stores to the display register and drives the 7-segment driver's 32-bit data/enable inputs.
- Also drives a 24-bit LED bank.
- Synchronises and debounces switches/buttons and returns them on CPU loads. Buttons have sticky press events.

Parameters:
- DEBOUNCE_CYCLES, 200000, consecutive stable cycles required to accept a button change (2 ms at 100 MHz).
- DISP_ADDR, 32'hFFFF_F000, display data register address.
- LED_ADDR, 32'hFFFF_F060, LED register address.
- SW_ADDR, 32'hFFFF_F070, switch status address (read-only).
- BTN_ADDR, 32'hFFFF_F078, button status/event address.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cpu_addr  in  32  byte address; full 32-bit compare against the map.
- cpu_we  in  1  store strobe, sampled on posedge clk.
- cpu_wdata  in  32  store data.
- cpu_rdata  out  32  load data, combinational from cpu_addr and registered state.
- sw_in  in  24  asynchronous switch inputs.
- btn_in  in  5  asynchronous button inputs, active-high.
- led_out  out  24  LED drive, registered.
- disp_data  out  32  value for the 7-segment driver, registered.
- disp_en  out  1  one-cycle load strobe for the 7-segment driver.

Behaviour:
- Reset: led_out=0, disp_data=0, disp_en=0, synchronisers=0, btn_stable=0, btn_event=0, debounce counters=0, all FSMs in IDLE.
- Display store (cpu_we && cpu_addr==DISP_ADDR):
  - Edge N: disp_data<=cpu_wdata and disp_en<=1.
  - Edge N+1: disp_en<=0 unless another DISP_ADDR store occurs.
  - Back-to-back stores hold disp_en high, and disp_data tracks each store.
- LED store: led_out<=cpu_wdata[23:0] on the store edge. Upper bits are ignored.
- Stores to SW_ADDR or to unmapped addresses: ignored, with no side effects.
- Switches: 2-flop synchroniser, no debounce. A sw_in change is visible on cpu_rdata after 2 edges.
- Buttons: 2-flop synchroniser per bit, then one debouncer per bit.
- Debouncer FSM per bit:
  - IDLE: if sync != stable, clear the counter and go to COUNT.
  - COUNT: if sync == stable, return to IDLE (glitch rejected). Otherwise increment the counter.
  - When counter == DEBOUNCE_CYCLES-1: stable <= sync, emit a 1-cycle rise pulse if the new value is 1, go to IDLE.
  - Counter width is $clog2(DEBOUNCE_CYCLES). Counter never wraps.
- btn_event[i]:
  - Set by rise[i].
  - Cleared by a store to BTN_ADDR with cpu_wdata[5+i]=1 (write-1-to-clear).
  - Simultaneous set and clear on the same edge: set wins.
- Load map (cpu_rdata, combinational):
  - DISP_ADDR: disp_data.
  - LED_ADDR: {8'b0, led_out}.
  - SW_ADDR: {8'b0, sw_sync}.
  - BTN_ADDR: {22'b0, btn_event[4:0], btn_stable[4:0]}.
  - Any other address: 32'h0.
  - Loads have no side effects; events are not clear-on-read.
- Reset asserted mid-debounce or mid-strobe: everything returns immediately to reset values. disp_en drops asynchronously.
- Total button latency from btn_in edge to btn_stable: 2 + DEBOUNCE_CYCLES edges.

Decomposition:
- Shared package io_map_pkg holds:
  - the four address constants;
  - the BTN field offsets (STABLE_LSB=0, EVENT_LSB=5);
  - widths SW_W=24, BTN_W=5.
- The parameter defaults reference these constants.
- One sub-module, btn_debounce:
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, rst, din, stable, rise.
  - Contains the synchroniser, counter and FSM.
  - Instantiated BTN_W times via generate.

Test Plan (bench overrides DEBOUNCE_CYCLES=4):
- Display store: cpu_we=1, addr=32'hFFFF_F000, wdata=32'h1234_ABCD for 1 cycle -> next edge disp_data=32'h1234_ABCD and disp_en=1 for exactly 1 cycle. A load of DISP_ADDR returns 32'h1234_ABCD.
- Back-to-back stores: 32'h1, 32'h2, 32'h3 on consecutive cycles -> disp_en high for 3 cycles, disp_data 1,2,3, then 0 strobe. A store to 32'hFFFF_F004 -> no disp_en.
- LED and switches:
  - Store 32'hFFAA_5501 to LED_ADDR -> led_out=24'hAA5501.
  - Drive sw_in=24'hC3C3C3 -> load SW_ADDR returns 32'h00C3C3C3 two edges later, and 0 before that.
- Button glitch and press:
  - btn_in[2] high for 3 cycles then low -> btn_stable and btn_event stay 0.
  - btn_in[2] held high -> after 2+4 edges btn_stable[2]=1 and btn_event[2]=1. BTN_ADDR load returns 32'h0000_0084.
- Event clear:
  - Store wdata=32'h80 to BTN_ADDR -> btn_event[2]=0, btn_stable unchanged.
  - Store coinciding with a new rise on bit 2 -> btn_event[2] stays 1.
- Async reset: assert rst mid-COUNT and during disp_en=1 -> all outputs 0 immediately. After release, a press needs a full 2+4 edges to register.
